// File: rtl/sha2_kround_seq_if.sv
// Handshake bundle between the SHA-2 round sequencer and its driver:
// block-control inputs plus the per-round K/index/control outputs.
interface sha2_kround_seq_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              last_blk;
    logic              stall;
    logic              abort;
    logic [WORD_W-1:0] k_out;
    logic [6:0]        round_idx;
    logic              k_valid;
    logic              sched_load;
    logic              round_last;
    logic              first_blk;
    logic              blk_done;
    logic              msg_done;
    logic              busy;
    logic              err_start;

    modport master (
        output start, last_blk, stall, abort,
        input  k_out, round_idx, k_valid, sched_load, round_last, first_blk,
               blk_done, msg_done, busy, err_start
    );

    modport slave (
        input  start, last_blk, stall, abort,
        output k_out, round_idx, k_valid, sched_load, round_last, first_blk,
               blk_done, msg_done, busy, err_start
    );
endinterface

// File: rtl/sha2_kround_seq.sv
// SHA-256/SHA-512 round sequencer: walks one block through all rounds,
// emitting round index, registered K constant and scheduler/digest control.
module sha2_kround_seq #(
    parameter int WORD_W = 32
) (
    input logic              clk,
    input logic              rst,
    sha2_kround_seq_if.slave bus
);

    localparam int         ROUNDS   = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha2_kround_seq: WORD_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // SHA-512 constants; the SHA-256 set is exactly their upper 32 bits.
    function automatic logic [WORD_W-1:0] k_word(input logic [6:0] i);
        logic [63:0] kv;
        case (i)
            7'd0:  kv = 64'h428a2f98d728ae22;
            7'd1:  kv = 64'h7137449123ef65cd;
            7'd2:  kv = 64'hb5c0fbcfec4d3b2f;
            7'd3:  kv = 64'he9b5dba58189dbbc;
            7'd4:  kv = 64'h3956c25bf348b538;
            7'd5:  kv = 64'h59f111f1b605d019;
            7'd6:  kv = 64'h923f82a4af194f9b;
            7'd7:  kv = 64'hab1c5ed5da6d8118;
            7'd8:  kv = 64'hd807aa98a3030242;
            7'd9:  kv = 64'h12835b0145706fbe;
            7'd10: kv = 64'h243185be4ee4b28c;
            7'd11: kv = 64'h550c7dc3d5ffb4e2;
            7'd12: kv = 64'h72be5d74f27b896f;
            7'd13: kv = 64'h80deb1fe3b1696b1;
            7'd14: kv = 64'h9bdc06a725c71235;
            7'd15: kv = 64'hc19bf174cf692694;
            7'd16: kv = 64'he49b69c19ef14ad2;
            7'd17: kv = 64'hefbe4786384f25e3;
            7'd18: kv = 64'h0fc19dc68b8cd5b5;
            7'd19: kv = 64'h240ca1cc77ac9c65;
            7'd20: kv = 64'h2de92c6f592b0275;
            7'd21: kv = 64'h4a7484aa6ea6e483;
            7'd22: kv = 64'h5cb0a9dcbd41fbd4;
            7'd23: kv = 64'h76f988da831153b5;
            7'd24: kv = 64'h983e5152ee66dfab;
            7'd25: kv = 64'ha831c66d2db43210;
            7'd26: kv = 64'hb00327c898fb213f;
            7'd27: kv = 64'hbf597fc7beef0ee4;
            7'd28: kv = 64'hc6e00bf33da88fc2;
            7'd29: kv = 64'hd5a79147930aa725;
            7'd30: kv = 64'h06ca6351e003826f;
            7'd31: kv = 64'h142929670a0e6e70;
            7'd32: kv = 64'h27b70a8546d22ffc;
            7'd33: kv = 64'h2e1b21385c26c926;
            7'd34: kv = 64'h4d2c6dfc5ac42aed;
            7'd35: kv = 64'h53380d139d95b3df;
            7'd36: kv = 64'h650a73548baf63de;
            7'd37: kv = 64'h766a0abb3c77b2a8;
            7'd38: kv = 64'h81c2c92e47edaee6;
            7'd39: kv = 64'h92722c851482353b;
            7'd40: kv = 64'ha2bfe8a14cf10364;
            7'd41: kv = 64'ha81a664bbc423001;
            7'd42: kv = 64'hc24b8b70d0f89791;
            7'd43: kv = 64'hc76c51a30654be30;
            7'd44: kv = 64'hd192e819d6ef5218;
            7'd45: kv = 64'hd69906245565a910;
            7'd46: kv = 64'hf40e35855771202a;
            7'd47: kv = 64'h106aa07032bbd1b8;
            7'd48: kv = 64'h19a4c116b8d2d0c8;
            7'd49: kv = 64'h1e376c085141ab53;
            7'd50: kv = 64'h2748774cdf8eeb99;
            7'd51: kv = 64'h34b0bcb5e19b48a8;
            7'd52: kv = 64'h391c0cb3c5c95a63;
            7'd53: kv = 64'h4ed8aa4ae3418acb;
            7'd54: kv = 64'h5b9cca4f7763e373;
            7'd55: kv = 64'h682e6ff3d6b2b8a3;
            7'd56: kv = 64'h748f82ee5defb2fc;
            7'd57: kv = 64'h78a5636f43172f60;
            7'd58: kv = 64'h84c87814a1f0ab72;
            7'd59: kv = 64'h8cc702081a6439ec;
            7'd60: kv = 64'h90befffa23631e28;
            7'd61: kv = 64'ha4506cebde82bde9;
            7'd62: kv = 64'hbef9a3f7b2c67915;
            7'd63: kv = 64'hc67178f2e372532b;
            7'd64: kv = 64'hca273eceea26619c;
            7'd65: kv = 64'hd186b8c721c0c207;
            7'd66: kv = 64'heada7dd6cde0eb1e;
            7'd67: kv = 64'hf57d4f7fee6ed178;
            7'd68: kv = 64'h06f067aa72176fba;
            7'd69: kv = 64'h0a637dc5a2c898a6;
            7'd70: kv = 64'h113f9804bef90dae;
            7'd71: kv = 64'h1b710b35131c471b;
            7'd72: kv = 64'h28db77f523047d84;
            7'd73: kv = 64'h32caab7b40c72493;
            7'd74: kv = 64'h3c9ebe0a15c9bebc;
            7'd75: kv = 64'h431d67c49c100d4c;
            7'd76: kv = 64'h4cc5d4becb3e42b6;
            7'd77: kv = 64'h597f299cfc657e2a;
            7'd78: kv = 64'h5fcb6fab3ad6faec;
            7'd79: kv = 64'h6c44198c4a475817;
            default: kv = 64'h0000_0000_0000_0000;
        endcase
        return kv[63 -: WORD_W];
    endfunction

    state_t            state_r, state_s;
    logic [6:0]        idx_r, idx_s;
    logic [WORD_W-1:0] k_r, k_s;
    logic              valid_r, valid_s;
    logic              sched_r, sched_s;
    logic              rlast_r, rlast_s;
    logic              first_blk_r, first_blk_s;
    logic              blk_done_r, blk_done_s;
    logic              msg_done_r, msg_done_s;
    logic              busy_r, busy_s;
    logic              err_r, err_s;
    logic              first_flag_r, first_flag_s;
    logic              last_r, last_s;

    // Next-state and next-output decode; abort overrides everything.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        first_blk_s  = first_blk_r;
        first_flag_s = first_flag_r;
        last_s       = last_r;
        blk_done_s   = 1'b0;
        msg_done_s   = 1'b0;
        err_s        = 1'b0;
        if (bus.abort) begin
            state_s      = ST_IDLE;
            idx_s        = 7'd0;
            first_blk_s  = 1'b0;
            first_flag_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_s     = ST_RUN;
                        idx_s       = 7'd0;
                        first_blk_s = first_flag_r;
                        last_s      = bus.last_blk;
                    end else begin
                        state_s     = ST_IDLE;
                        idx_s       = 7'd0;
                        first_blk_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    err_s = bus.start;
                    if (bus.stall) begin
                        idx_s = idx_r;
                    end else if (idx_r == LAST_IDX) begin
                        // Flag is updated on entry to DONE so a back-to-back start sees it.
                        state_s      = ST_DONE;
                        idx_s        = 7'd0;
                        first_blk_s  = 1'b0;
                        blk_done_s   = 1'b1;
                        msg_done_s   = last_r;
                        first_flag_s = last_r;
                    end else begin
                        idx_s = idx_r + 7'd1;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    idx_s       = 7'd0;
                    first_blk_s = 1'b0;
                end
            endcase
        end

        valid_s = (state_s == ST_RUN);
        busy_s  = (state_s != ST_IDLE);
        if (valid_s) begin
            k_s     = k_word(idx_s);
            sched_s = (idx_s < 7'd16);
            rlast_s = (idx_s == LAST_IDX);
        end else begin
            k_s     = '0;
            sched_s = 1'b0;
            rlast_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and message-level flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r        <= 7'd0;
            k_r          <= '0;
            valid_r      <= 1'b0;
            sched_r      <= 1'b0;
            rlast_r      <= 1'b0;
            first_blk_r  <= 1'b0;
            blk_done_r   <= 1'b0;
            msg_done_r   <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            first_flag_r <= 1'b1;
            last_r       <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            k_r          <= k_s;
            valid_r      <= valid_s;
            sched_r      <= sched_s;
            rlast_r      <= rlast_s;
            first_blk_r  <= first_blk_s;
            blk_done_r   <= blk_done_s;
            msg_done_r   <= msg_done_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
            first_flag_r <= first_flag_s;
            last_r       <= last_s;
        end
    end

    assign bus.k_out      = k_r;
    assign bus.round_idx  = idx_r;
    assign bus.k_valid    = valid_r;
    assign bus.sched_load = sched_r;
    assign bus.round_last = rlast_r;
    assign bus.first_blk  = first_blk_r;
    assign bus.blk_done   = blk_done_r;
    assign bus.msg_done   = msg_done_r;
    assign bus.busy       = busy_r;
    assign bus.err_start  = err_r;

endmodule

// File: tb/tb_sha2_kround_seq.sv
// Bench for sha2_kround_seq: 32- and 64-bit instances checked every cycle
// against a round-counter model whose K tables are derived from prime cube roots.
module tb_sha2_kround_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha2_kround_seq_if #(.WORD_W(32)) bus32 ();
    sha2_kround_seq_if #(.WORD_W(64)) bus64 ();

    sha2_kround_seq #(.WORD_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    sha2_kround_seq #(.WORD_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    logic sel = 1'b0;
    logic start_d = 1'b0, last_d = 1'b0, stall_d = 1'b0, abort_d = 1'b0;

    assign bus32.start    = start_d & ~sel;
    assign bus32.last_blk = last_d  & ~sel;
    assign bus32.stall    = stall_d & ~sel;
    assign bus32.abort    = abort_d & ~sel;
    assign bus64.start    = start_d & sel;
    assign bus64.last_blk = last_d  & sel;
    assign bus64.stall    = stall_d & sel;
    assign bus64.abort    = abort_d & sel;

    logic [63:0] o_k;
    logic [6:0]  o_idx;
    logic        o_valid, o_rlast, o_first, o_blk, o_msg, o_busy, o_err;
    assign o_k     = sel ? bus64.k_out      : {32'd0, bus32.k_out};
    assign o_idx   = sel ? bus64.round_idx  : bus32.round_idx;
    assign o_valid = sel ? bus64.k_valid    : bus32.k_valid;
    assign o_rlast = sel ? bus64.round_last : bus32.round_last;
    assign o_first = sel ? bus64.first_blk  : bus32.first_blk;
    assign o_blk   = sel ? bus64.blk_done   : bus32.blk_done;
    assign o_msg   = sel ? bus64.msg_done   : bus32.msg_done;
    assign o_busy  = sel ? bus64.busy       : bus32.busy;
    assign o_err   = sel ? bus64.err_start  : bus32.err_start;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // K tables: fractional bits of cube roots of the first 80 primes.
    logic [31:0] k32_t [64];
    logic [63:0] k64_t [80];

    function automatic logic [63:0] cube_frac(input int p, input int fbits);
        logic [255:0] n, r, t;
        n = 256'(p) << (3 * fbits);
        r = '0;
        for (int b = 70; b >= 0; b--) begin
            t = r | (256'd1 << b);
            if (t * t * t <= n) r = t;
        end
        if (fbits == 32) return {32'd0, r[31:0]};
        return r[63:0];
    endfunction

    task automatic build_tables();
        int cnt = 0;
        int p = 2;
        logic [63:0] v;
        while (cnt < 80) begin
            bit prime = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
            if (prime) begin
                k64_t[cnt] = cube_frac(p, 64);
                if (cnt < 64) begin
                    v = cube_frac(p, 32);
                    k32_t[cnt] = v[31:0];
                end
                cnt++;
            end
            p++;
        end
    endtask

    // Model: round = -1 idle, 0..R-1 running, R = done cycle.
    typedef struct {
        int round;
        bit ff;
        bit last;
        bit first;
        bit err;
    } mst_t;

    mst_t m [2];

    function automatic mst_t m_next(mst_t s, int r, bit st, bit lb, bit sl, bit ab);
        mst_t n = s;
        n.err = 1'b0;
        if (ab) begin
            n.round = -1;
            n.ff    = 1'b1;
        end else if (s.round < 0 || s.round == r) begin
            if (st) begin
                n.round = 0;
                n.first = s.ff;
                n.last  = lb;
            end else begin
                n.round = -1;
            end
        end else begin
            n.err = st;
            if (!sl) begin
                if (s.round == r - 1) begin
                    n.round = r;
                    n.ff    = s.last;
                end else begin
                    n.round = s.round + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) m[i] <= '{round: -1, ff: 1'b1, last: 1'b0, first: 1'b0, err: 1'b0};
        end else begin
            m[0] <= m_next(m[0], 64, bus32.start, bus32.last_blk, bus32.stall, bus32.abort);
            m[1] <= m_next(m[1], 80, bus64.start, bus64.last_blk, bus64.stall, bus64.abort);
        end
    end

    task automatic cmp_inst(input int i);
        mst_t s;
        int r;
        bit v;
        logic [63:0] ek;
        logic [78:0] e, a;
        s  = m[i];
        r  = (i == 0) ? 64 : 80;
        v  = (s.round >= 0) && (s.round < r);
        ek = 64'd0;
        if (v) ek = (i == 0) ? {32'd0, k32_t[s.round]} : k64_t[s.round];
        e = {ek, v ? 7'(s.round) : 7'd0, v, v && s.round < 16, v && s.round == r - 1,
             v && s.first, s.round == r, s.round == r && s.last, s.round != -1, s.err};
        if (i == 0)
            a = {32'd0, bus32.k_out, bus32.round_idx, bus32.k_valid, bus32.sched_load,
                 bus32.round_last, bus32.first_blk, bus32.blk_done, bus32.msg_done,
                 bus32.busy, bus32.err_start};
        else
            a = {bus64.k_out, bus64.round_idx, bus64.k_valid, bus64.sched_load,
                 bus64.round_last, bus64.first_blk, bus64.blk_done, bus64.msg_done,
                 bus64.busy, bus64.err_start};
        chk(i == 0 ? "model32" : "model64", {1'b0, a}, {1'b0, e});
    endtask

    always @(negedge clk) begin
        cmp_inst(0);
        cmp_inst(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block on the selected instance; returns in its DONE cycle.
    task automatic run_blk(input bit lb, input bit exp_first, input int stall_at, input int stall_n,
                           input int err_at, input int exp_n, input bit exp_msg);
        int n = 0, st = 0, guard = 0;
        bit err_pend = 1'b0, err_done = 1'b0;
        int last_idx = sel ? 79 : 63;
        start_d = 1'b1;
        last_d  = lb;
        tick();
        start_d = 1'b0;
        last_d  = 1'b0;
        chk("idx0", {73'd0, o_idx}, 80'd0);
        chk("first_blk", {79'd0, o_first}, {79'd0, exp_first});
        chk("k0", {16'd0, o_k}, sel ? 80'h428a2f98d728ae22 : 80'h428a2f98);
        while (o_valid && guard < 300) begin
            guard++;
            n++;
            start_d = 1'b0;
            stall_d = 1'b0;
            if (err_pend) begin
                chk("err_start", {79'd0, o_err}, 80'd1);
                chk("idx_after_err", {73'd0, o_idx}, 80'(err_at + 1));
                err_pend = 1'b0;
            end
            if (!sel && int'(o_idx) == 1) chk("k1", {16'd0, o_k}, 80'h71374491);
            if (!sel && int'(o_idx) == 10) chk("k10", {16'd0, o_k}, 80'h243185be);
            if (int'(o_idx) == stall_at && st < stall_n) begin
                stall_d = 1'b1;
                st++;
            end
            if (int'(o_idx) == err_at && !err_done) begin
                start_d  = 1'b1;
                err_done = 1'b1;
                err_pend = 1'b1;
            end
            if (int'(o_idx) == last_idx && !stall_d) begin
                chk("round_last", {79'd0, o_rlast}, 80'd1);
                chk("k_last", {16'd0, o_k}, sel ? 80'h6c44198c4a475817 : 80'hc67178f2);
            end
            tick();
        end
        start_d = 1'b0;
        stall_d = 1'b0;
        if (guard >= 300) chk("run_timeout", 80'd1, 80'd0);
        chk("valid_cycles", 80'(n), 80'(exp_n));
        chk("blk_done", {79'd0, o_blk}, 80'd1);
        chk("msg_done", {79'd0, o_msg}, {79'd0, exp_msg});
    endtask

    initial begin
        int guard;
        build_tables();
        chk("tab_k32_0", {48'd0, k32_t[0]}, 80'h428a2f98);
        chk("tab_k32_10", {48'd0, k32_t[10]}, 80'h243185be);
        chk("tab_k32_63", {48'd0, k32_t[63]}, 80'hc67178f2);
        chk("tab_k64_0", {16'd0, k64_t[0]}, 80'h428a2f98d728ae22);
        chk("tab_k64_79", {16'd0, k64_t[79]}, 80'h6c44198c4a475817);

        repeat (3) tick();
        chk("rst_busy", {79'd0, o_busy}, 80'd0);
        chk("rst_k", {16'd0, o_k}, 80'd0);
        rst = 1'b1;
        tick();

        // Basic block, stall at idx10, start inside RUN.
        run_blk(1'b1, 1'b1, -1, 0, -1, 64, 1'b1);
        tick();
        run_blk(1'b1, 1'b1, 10, 3, -1, 67, 1'b1);
        tick();
        run_blk(1'b1, 1'b1, -1, 0, 20, 64, 1'b1);
        tick();

        // Two-block message, B started in A's DONE cycle, then a fresh message.
        run_blk(1'b0, 1'b1, -1, 0, -1, 64, 1'b0);
        run_blk(1'b1, 1'b0, -1, 0, -1, 64, 1'b1);
        tick();
        run_blk(1'b1, 1'b1, -1, 0, -1, 64, 1'b1);
        tick();

        // Abort together with start at idx30.
        start_d = 1'b1;
        last_d  = 1'b0;
        tick();
        start_d = 1'b0;
        guard = 0;
        while (int'(o_idx) != 30 && guard < 100) begin
            guard++;
            tick();
        end
        if (guard >= 100) chk("idx30_timeout", 80'd1, 80'd0);
        abort_d = 1'b1;
        start_d = 1'b1;
        tick();
        abort_d = 1'b0;
        start_d = 1'b0;
        chk("abort_busy", {79'd0, o_busy}, 80'd0);
        chk("abort_valid", {79'd0, o_valid}, 80'd0);
        chk("abort_k", {16'd0, o_k}, 80'd0);
        chk("abort_blk_done", {79'd0, o_blk}, 80'd0);
        repeat (3) tick();

        // Asynchronous reset mid-run, away from any clock edge.
        start_d = 1'b1;
        last_d  = 1'b1;
        tick();
        start_d = 1'b0;
        last_d  = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        chk("async_busy", {79'd0, o_busy}, 80'd0);
        chk("async_valid", {79'd0, o_valid}, 80'd0);
        chk("async_k", {16'd0, o_k}, 80'd0);
        chk("async_idx", {73'd0, o_idx}, 80'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // SHA-512 instance.
        sel = 1'b1;
        run_blk(1'b1, 1'b1, -1, 0, -1, 80, 1'b1);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
